multicycle_ctrl: RTL



---
 rtl/multicycle_ctrl.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_ctrl.sv
// ---------------------------------------------------------------------------
// multicycle_ctrl
//
// Control sequencer for a multicycle ARM datapath with a shared ALU and a
// shared instruction/data memory. Each instruction is stepped through
// Fetch / Decode / Execute / Memory / Writeback states. The block holds the
// NZCV flags, evaluates the condition field, and emits per-cycle mux selects
// and condition-gated write enables.
//
// Ports
//   clk          in   system clock, all state updates on the rising edge
//   reset        in   synchronous, active-high
//   Cond[3:0]    in   Instr[31:28]
//   Op[1:0]      in   Instr[27:26]
//   Funct[5:0]   in   Instr[25:20]: [5]=I, [4:1]=cmd, [0]=S/L
//   Rd[3:0]      in   Instr[15:12]
//   ALUFlags[3:0] in  live ALU NZCV ([3]=N .. [0]=V)
//   PCWrite, IRWrite, RegWrite, MemWrite   out  write enables
//   AdrSrc, ALUSrcA                        out  1-bit selects
//   ALUSrcB, ResultSrc, ALUControl         out  2-bit selects
//   ImmSrc, RegSrc                         out  combinational from Op
//   State[3:0]   out  current state code (debug)
//
// Build option
//   MCCTRL_CMP_EN  when defined, cmd 1010 (CMP) is a subtract that only
//                  updates flags: EXECR/EXECI return straight to FETCH.
// ---------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       AdrSrc,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    localparam logic [3:0] S_FETCH  = 4'd0;
    localparam logic [3:0] S_DECODE = 4'd1;
    localparam logic [3:0] S_MEMADR = 4'd2;
    localparam logic [3:0] S_MEMRD  = 4'd3;
    localparam logic [3:0] S_MEMWB  = 4'd4;
    localparam logic [3:0] S_MEMWR  = 4'd5;
    localparam logic [3:0] S_EXECR  = 4'd6;
    localparam logic [3:0] S_EXECI  = 4'd7;
    localparam logic [3:0] S_ALUWB  = 4'd8;
    localparam logic [3:0] S_BRANCH = 4'd9;

    logic [3:0] r_state;
    logic [3:0] r_flags;      // {N, Z, C, V}
    logic       r_condexr;

    logic [3:0] w_next_state;
    logic [3:0] w_dec_state;
    logic [3:0] w_cmd;
    logic       w_is_cmp;
    logic       w_condex;
    logic       w_in_exec;
    logic       w_flag_we;
    logic       w_cv_upd;
    logic       w_pcw_raw;
    logic       w_irw_raw;
    logic       w_rw_raw;
    logic       w_mw_raw;

    assign w_cmd = Funct[4:1];

`ifdef MCCTRL_CMP_EN
    assign w_is_cmp = (w_cmd == 4'b1010);
`else
    assign w_is_cmp = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Condition evaluation against the registered flags
    // -----------------------------------------------------------------------
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can
        // leave it unassigned and infer a latch.
        w_condex = 1'b0;
        case (Cond)
            4'b0000: w_condex = r_flags[2];
            4'b0001: w_condex = !r_flags[2];
            4'b0010: w_condex = r_flags[1];
            4'b0011: w_condex = !r_flags[1];
            4'b0100: w_condex = r_flags[3];
            4'b0101: w_condex = !r_flags[3];
            4'b0110: w_condex = r_flags[0];
            4'b0111: w_condex = !r_flags[0];
            4'b1000: w_condex = r_flags[1] && !r_flags[2];
            4'b1001: w_condex = !r_flags[1] || r_flags[2];
            4'b1010: w_condex = (r_flags[3] == r_flags[0]);
            4'b1011: w_condex = (r_flags[3] != r_flags[0]);
            4'b1100: w_condex = !r_flags[2] && (r_flags[3] == r_flags[0]);
            4'b1101: w_condex = r_flags[2] || (r_flags[3] != r_flags[0]);
            4'b1110: w_condex = 1'b1;
            default: w_condex = 1'b0;
        endcase
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        w_next_state = S_FETCH;
        case (r_state)
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                case (Op)
                    2'b00:   w_next_state = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   w_next_state = S_MEMADR;
                    2'b10:   w_next_state = S_BRANCH;
                    default: w_next_state = S_FETCH;
                endcase
            end
            S_MEMADR: w_next_state = Funct[0] ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next_state = S_MEMWB;
            S_EXECR,
            S_EXECI:  w_next_state = w_is_cmp ? S_FETCH : S_ALUWB;
            default:  w_next_state = S_FETCH;   // writeback states and illegal codes
        endcase
    end

    // -----------------------------------------------------------------------
    // Output decode. While reset is held the selects show FETCH decode and
    // all write enables are suppressed so nothing commits in a reset cycle.
    // -----------------------------------------------------------------------
    assign w_dec_state = reset ? S_FETCH : r_state;

    always_comb begin
        w_pcw_raw  = 1'b0;
        w_irw_raw  = 1'b0;
        w_rw_raw   = 1'b0;
        w_mw_raw   = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        ALUControl = 2'b00;
        case (w_dec_state)
            S_FETCH: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irw_raw = 1'b1;
                w_pcw_raw = 1'b1;
            end
            S_DECODE: begin
                ALUSrcA   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
            end
            S_MEMADR: ALUSrcB = 2'b01;
            S_MEMRD:  AdrSrc  = 1'b1;
            S_MEMWB: begin
                ResultSrc = 2'b01;
                w_rw_raw  = r_condexr;
                w_pcw_raw = r_condexr && (Rd == 4'd15);
            end
            S_MEMWR: begin
                AdrSrc   = 1'b1;
                w_mw_raw = r_condexr;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB = (w_dec_state == S_EXECI) ? 2'b01 : 2'b00;
                case (w_cmd)
                    4'b0100: ALUControl = 2'b00;
                    4'b0010: ALUControl = 2'b01;
                    4'b0000: ALUControl = 2'b10;
                    4'b1100: ALUControl = 2'b11;
                    default: ALUControl = w_is_cmp ? 2'b01 : 2'b00;
                endcase
            end
            S_ALUWB: begin
                w_rw_raw  = r_condexr;
                w_pcw_raw = r_condexr && (Rd == 4'd15);
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcw_raw = r_condexr;
            end
            default: ;
        endcase
    end

    assign PCWrite  = w_pcw_raw && !reset;
    assign IRWrite  = w_irw_raw && !reset;
    assign RegWrite = w_rw_raw  && !reset;
    assign MemWrite = w_mw_raw  && !reset;

    assign ImmSrc = Op;
    assign RegSrc = {(Op == 2'b01), (Op == 2'b10)};
    assign State  = r_state;

    // -----------------------------------------------------------------------
    // Flag write: on the edge leaving EXECR/EXECI for an executed S-form op.
    // C and V only carry meaning for arithmetic ops (ADD, SUB, and CMP when
    // it is enabled), so logical ops leave them untouched.
    // -----------------------------------------------------------------------
    assign w_in_exec = (r_state == S_EXECR) || (r_state == S_EXECI);
    assign w_flag_we = w_in_exec && Funct[0] && r_condexr;
    assign w_cv_upd  = (w_cmd == 4'b0100) || (w_cmd == 4'b0010) || w_is_cmp;

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values, independent of statement order.
        if (reset) begin
            r_state   <= S_FETCH;
            r_flags   <= 4'b0000;
            r_condexr <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_DECODE) begin
                r_condexr <= w_condex;
            end
            if (w_flag_we) begin
                r_flags[3:2] <= ALUFlags[3:2];
                if (w_cv_upd) begin
                    r_flags[1:0] <= ALUFlags[1:0];
                end
            end
        end
    end

endmodule
